wbl_write_seq: RTL

WBL_WRITE_SEQ -- requirements
Module: wbl_write_seq

---
 rtl/wbl_write_seq.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/wbl_write_seq.sv
// wbl_write_seq
// Sweeps the WBL key generator over rows 0..NUM_ROWS-1. For each row it waits
// KG_LAT cycles for the key-gen output to settle, captures all sixteen 64-bit
// WBL words, then streams them to the array with a valid/ready handshake.
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   start      one-cycle request to begin a sweep (honoured only in IDLE)
//   abort      return to IDLE next cycle (beats start and a coincident transfer)
//   kg_addr    address presented to the key generator
//   wbl_in     16 words, WBL1 in [1023:960] .. WBL16 in [63:0]
//   wr_valid   write request, high only in WRITE
//   wr_ready   array accepts the word
//   wr_row     row of the word being written
//   wr_sel     WBL index, 0 = WBL1 .. 15 = WBL16
//   wr_data    word being written (0 outside WRITE)
//   wr_par     even parity of wr_data (0 when WBL_PARITY_EN is undefined)
//   busy       high in every state except IDLE
//   done       one-cycle pulse when the sweep completes
//
// Build option: define WBL_PARITY_EN to generate the registered wr_par.
//
// state   | meaning
// IDLE    | waiting for start
// SETTLE  | kg_addr stable, waiting KG_LAT cycles for the key generator
// CAPTURE | snapshot wbl_in into the row buffer
// WRITE   | present buffer[wr_sel] until the array takes it
// DONE    | one-cycle completion pulse
module wbl_write_seq #(
  parameter int NUM_ROWS = 64,
  parameter int KG_LAT   = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  output logic [5:0]    kg_addr,
  input  logic [1023:0] wbl_in,
  output logic          wr_valid,
  input  logic          wr_ready,
  output logic [5:0]    wr_row,
  output logic [3:0]    wr_sel,
  output logic [63:0]   wr_data,
  output logic          wr_par,
  output logic          busy,
  output logic          done
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SETTLE  = 3'd1,
    S_CAPTURE = 3'd2,
    S_WRITE   = 3'd3,
    S_DONE    = 3'd4
  } state_e;

  localparam logic [5:0] LAST_ROW    = 6'(NUM_ROWS - 1);
  localparam logic [2:0] LAST_SETTLE = 3'(KG_LAT - 1);

  state_e      state_q, state_d;
  logic [5:0]  kg_addr_q, kg_addr_d;
  logic [2:0]  settle_cnt_q, settle_cnt_d;
  logic [5:0]  wr_row_q, wr_row_d;
  logic [3:0]  wr_sel_q, wr_sel_d;
  logic [63:0] wr_data_q, wr_data_d;
  logic [63:0] buf_q [16];

  logic xfer;
  logic last_word;
  logic settle_end;

  assign xfer       = (state_q == S_WRITE) && wr_ready;
  assign last_word  = (wr_sel_q == 4'd15);
  assign settle_end = (settle_cnt_q == LAST_SETTLE);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:    if (start) state_d = S_SETTLE;
        S_SETTLE:  if (settle_end) state_d = S_CAPTURE;
        S_CAPTURE: state_d = S_WRITE;
        S_WRITE:   if (xfer && last_word)
                     state_d = (kg_addr_q < LAST_ROW) ? S_SETTLE : S_DONE;
        S_DONE:    state_d = S_IDLE;
        default:   state_d = S_IDLE;
      endcase
    end
  end

  // Datapath next values. wr_data is registered so that the parity flop
  // can be computed from the same next value and stay cycle-aligned.
  always_comb begin
    kg_addr_d    = kg_addr_q;
    settle_cnt_d = settle_cnt_q;
    wr_row_d     = wr_row_q;
    wr_sel_d     = wr_sel_q;
    wr_data_d    = wr_data_q;
    if (!abort) begin
      case (state_q)
        S_IDLE: if (start) begin
          kg_addr_d    = '0;
          settle_cnt_d = '0;
        end
        S_SETTLE: if (!settle_end) settle_cnt_d = settle_cnt_q + 3'd1;
        S_CAPTURE: begin
          wr_row_d  = kg_addr_q;
          wr_sel_d  = '0;
          wr_data_d = wbl_in[1023 -: 64];
        end
        S_WRITE: if (xfer) begin
          if (!last_word) begin
            wr_sel_d  = wr_sel_q + 4'd1;
            wr_data_d = buf_q[wr_sel_q + 4'd1];
          end else if (kg_addr_q < LAST_ROW) begin
            kg_addr_d    = kg_addr_q + 6'd1;
            settle_cnt_d = '0;
          end
        end
        default: ;
      endcase
    end
    if (state_d != S_WRITE) wr_data_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      kg_addr_q    <= '0;
      settle_cnt_q <= '0;
      wr_row_q     <= '0;
      wr_sel_q     <= '0;
      wr_data_q    <= '0;
    end else begin
      kg_addr_q    <= kg_addr_d;
      settle_cnt_q <= settle_cnt_d;
      wr_row_q     <= wr_row_d;
      wr_sel_q     <= wr_sel_d;
      wr_data_q    <= wr_data_d;
    end
  end

  // Row buffer: loaded only in CAPTURE, so later wbl_in activity is ignored.
  always_ff @(posedge clk) begin
    if (state_q == S_CAPTURE) begin
      for (int i = 0; i < 16; i++) buf_q[i] <= wbl_in[1023 - 64*i -: 64];
    end
  end

  // Output logic
  always_comb begin
    wr_valid = (state_q == S_WRITE);
    busy     = (state_q != S_IDLE);
    done     = (state_q == S_DONE);
  end

  assign kg_addr = kg_addr_q;
  assign wr_row  = wr_row_q;
  assign wr_sel  = wr_sel_q;
  assign wr_data = wr_data_q;

`ifdef WBL_PARITY_EN
  logic wr_par_q;
  always_ff @(posedge clk) begin
    if (!rst_n) wr_par_q <= 1'b0;
    else        wr_par_q <= ^wr_data_d;
  end
  assign wr_par = wr_par_q;
`else
  assign wr_par = 1'b0;
`endif

endmodule
